// File: rtl/arith_seq_pkg.sv
// Shared state encoding and default widths for the arithmetic sequencer.
package arith_seq_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 11;
  localparam int CYCLES_WIDTH   = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/arith_sequencer_if.sv
// Operand RAM read port, operator issue/return and result RAM write port.
interface arith_sequencer_if
  import arith_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  // Valid-only streams, no back-pressure: opnd_valid qualifies opnd_a/opnd_b for
  // one cycle and must be taken; res_valid qualifies res for one cycle, results in
  // issue order; we_res qualifies addr_res/data_res; q_x/q_y follow addr_op by one cycle.
  logic [ADDR_WIDTH-1:0] addr_op;
  logic [DATA_WIDTH-1:0] q_x;
  logic [DATA_WIDTH-1:0] q_y;
  logic                  opnd_valid;
  logic [DATA_WIDTH-1:0] opnd_a;
  logic [DATA_WIDTH-1:0] opnd_b;
  logic                  res_valid;
  logic [DATA_WIDTH-1:0] res;
  logic [ADDR_WIDTH-1:0] addr_res;
  logic                  we_res;
  logic [DATA_WIDTH-1:0] data_res;

  modport master (
    output addr_op, opnd_valid, opnd_a, opnd_b, addr_res, we_res, data_res,
    input  q_x, q_y, res_valid, res
  );

  modport slave (
    input  addr_op, opnd_valid, opnd_a, opnd_b, addr_res, we_res, data_res,
    output q_x, q_y, res_valid, res
  );

endinterface

// File: rtl/seq_counter.sv
// Loadable up-counter that sticks at all-ones instead of wrapping.
module seq_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/arith_sequencer.sv
// Streams X/Y operand words through an external operator and writes the
// in-order results back to the result RAM, counting the cycles of each run.
module arith_sequencer
  import arith_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                    ram_clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_WIDTH:0]     length,
  output logic                    busy,
  output logic                    done,
  output logic [CYCLES_WIDTH-1:0] cycles,
  output logic                    err_extra,
  output state_t                  state_dbg,
  arith_sequencer_if.master       bus
);

  // One extra bit so a full 2^ADDR_WIDTH run can be counted without wrapping.
  localparam int CW = ADDR_WIDTH + 1;

  state_t                state, state_n;
  logic [CW-1:0]         len_q, rd_cnt, wr_cnt;
  logic                  go_run, go_zero, rd_en, wr_acc, wr_last, extra, active;
  logic                  opnd_valid_q, we_res_q;
  logic [ADDR_WIDTH-1:0] addr_res_q;
  logic [DATA_WIDTH-1:0] data_res_q;

  always_comb begin
    state_n = state;
    go_run  = 1'b0;
    go_zero = 1'b0;
    rd_en   = 1'b0;
    active  = (state == ST_READ) || (state == ST_DRAIN);
    wr_acc  = bus.res_valid && active && (wr_cnt < len_q);
    wr_last = wr_acc && (wr_cnt == len_q - CW'(1));
    extra   = bus.res_valid && !wr_acc;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start && (length != '0)) begin
          go_run  = 1'b1;
          state_n = ST_READ;
        end else if (start) begin
          go_zero = 1'b1;
          state_n = ST_DONE;
        end
      end
      ST_READ: begin
        rd_en = (rd_cnt != len_q - CW'(1));
        if (wr_last)     state_n = ST_DONE;
        else if (!rd_en) state_n = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (wr_last) state_n = ST_DONE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge ram_clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  seq_counter #(.WIDTH(CW)) u_rd_cnt (
    .clk(ram_clock), .rst(reset), .load(go_run), .load_val('0), .en(rd_en), .count(rd_cnt)
  );

  seq_counter #(.WIDTH(CW)) u_wr_cnt (
    .clk(ram_clock), .rst(reset), .load(go_run), .load_val('0), .en(wr_acc), .count(wr_cnt)
  );

  seq_counter #(.WIDTH(CYCLES_WIDTH)) u_cycles (
    .clk(ram_clock), .rst(reset), .load(go_run || go_zero), .load_val('0), .en(active),
    .count(cycles)
  );

  always_ff @(posedge ram_clock) begin
    if (reset) begin
      len_q        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_extra    <= 1'b0;
      opnd_valid_q <= 1'b0;
      we_res_q     <= 1'b0;
      addr_res_q   <= '0;
      data_res_q   <= '0;
    end else begin
      busy         <= (state_n == ST_READ) || (state_n == ST_DRAIN);
      done         <= (state_n == ST_DONE);
      opnd_valid_q <= (state == ST_READ);
      we_res_q     <= wr_acc;
      if (wr_acc) begin
        addr_res_q <= wr_cnt[ADDR_WIDTH-1:0];
        data_res_q <= bus.res;
      end
      if (go_run) len_q <= length;
      if (extra)       err_extra <= 1'b1;
      else if (go_run) err_extra <= 1'b0;
    end
  end

  // The RAM output registers already hold the operands, so they pass straight through.
  assign bus.addr_op    = rd_cnt[ADDR_WIDTH-1:0];
  assign bus.opnd_valid = opnd_valid_q;
  assign bus.opnd_a     = bus.q_x;
  assign bus.opnd_b     = bus.q_y;
  assign bus.we_res     = we_res_q;
  assign bus.addr_res   = addr_res_q;
  assign bus.data_res   = data_res_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_arith_sequencer.sv
// Directed and randomized runs of arith_sequencer against RAM/operator models
// and an expected-write queue built from the operand RAM contents.
module tb_arith_sequencer;
  import arith_seq_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 11;
  localparam int DEPTH = 1 << AW;

  logic        ram_clock = 1'b0;
  logic        reset, start;
  logic [AW:0] length;
  logic        busy, done, err_extra;
  logic [31:0] cycles;
  state_t      state_dbg;

  arith_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  arith_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .ram_clock(ram_clock), .reset(reset), .start(start), .length(length),
    .busy(busy), .done(done), .cycles(cycles), .err_extra(err_extra),
    .state_dbg(state_dbg), .bus(bus)
  );

  // ---------------- clock / watchdog ----------------
  always #5 ram_clock = ~ram_clock;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters and scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [AW+DW-1:0] exp_q[$];
  logic [DW-1:0]    ram_x[DEPTH];
  logic [DW-1:0]    ram_y[DEPTH];
  logic [DW-1:0]    res_ram[DEPTH];

  int lat_mode;  // 0 = random 1..5 cycles, otherwise fixed latency
  int inject;
  int run_len, opnd_idx, opnd_cnt, first_opnd_n, last_opnd_n;
  int wr_seen, last_wr_addr, last_res_n;
  int ncyc = 0;
  int last_due = 0;
  logic [DW-1:0] pend_val[$];
  int            pend_due[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Registered-read operand RAMs.
  always @(posedge ram_clock) begin
    bus.q_x <= ram_x[bus.addr_op];
    bus.q_y <= ram_y[bus.addr_op];
  end

  // Operand monitor, write monitor and in-order adder with per-operand latency.
  always @(negedge ram_clock) begin
    int lat, due;
    logic [AW+DW-1:0] e;
    ncyc++;
    if (bus.opnd_valid === 1'b1) begin
      check("opnd_in_range", opnd_idx < run_len, 1);
      if (opnd_idx < run_len) begin
        check("opnd_a", bus.opnd_a, ram_x[opnd_idx]);
        check("opnd_b", bus.opnd_b, ram_y[opnd_idx]);
      end
      if (opnd_cnt == 0) first_opnd_n = ncyc;
      last_opnd_n = ncyc;
      opnd_cnt++;
      opnd_idx++;
      lat = (lat_mode == 0) ? int'($urandom_range(1, 5)) : lat_mode;
      due = ncyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_val.push_back(bus.opnd_a + bus.opnd_b);
      pend_due.push_back(due);
    end
    if (bus.we_res === 1'b1) begin
      res_ram[bus.addr_res] = bus.data_res;
      wr_seen++;
      last_wr_addr = int'(bus.addr_res);
      check("wr_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_addr", bus.addr_res, e[AW+DW-1:DW]);
        check("wr_data", bus.data_res, e[DW-1:0]);
      end
    end
    bus.res_valid = 1'b0;
    if (pend_due.size() > 0 && pend_due[0] == ncyc) begin
      bus.res_valid = 1'b1;
      bus.res       = pend_val.pop_front();
      void'(pend_due.pop_front());
      last_res_n    = ncyc;
    end else if (inject != 0) begin
      bus.res_valid = 1'b1;
      bus.res       = '0;
      inject        = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge ram_clock);
    #1;
  endtask

  task automatic fill_random(input int len);
    for (int i = 0; i < len; i++) begin
      ram_x[i] = $urandom();
      ram_y[i] = $urandom();
    end
  endtask

  task automatic begin_run(input int len);
    logic [AW-1:0] a;
    logic [DW-1:0] s;
    run_len  = len;
    opnd_idx = 0;
    opnd_cnt = 0;
    wr_seen  = 0;
    last_wr_addr = -1;
    first_opnd_n = 0;
    last_opnd_n  = 0;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      a = AW'(i);
      s = ram_x[i] + ram_y[i];
      exp_q.push_back({a, s});
    end
  endtask

  task automatic do_start(input int len);
    length = (AW + 1)'(len);
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    check(tag, done, 1);
  endtask

  task automatic check_run_end(input string tag, input int len);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_writes"}, wr_seen, len);
    check({tag, "_opnds"}, opnd_cnt, len);
    check({tag, "_expq_empty"}, exp_q.size(), 0);
    check({tag, "_err"}, err_extra, 0);
    check({tag, "_cycles"}, cycles, last_res_n - first_opnd_n + 2);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int snap, len;
    reset = 1'b1; start = 1'b0; length = '0; lat_mode = 3; inject = 0; run_len = 0;
    for (int i = 0; i < DEPTH; i++) begin
      ram_x[i] = '0; ram_y[i] = '0; res_ram[i] = '0;
    end
    repeat (3) tick();

    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_extra, 0);
    check("rst_cycles", cycles, 0);
    check("rst_addr_op", bus.addr_op, 0);
    check("rst_addr_res", bus.addr_res, 0);
    check("rst_we_res", bus.we_res, 0);
    check("rst_opnd_valid", bus.opnd_valid, 0);
    check("rst_state", state_dbg, ST_IDLE);
    reset = 1'b0;
    tick();

    // Four-word add, fixed 3-cycle operator.
    for (int i = 0; i < 4; i++) begin
      ram_x[i] = DW'(i + 1);
      ram_y[i] = DW'(10 * (i + 1));
      res_ram[i] = '1;
    end
    lat_mode = 3;
    begin_run(4);
    do_start(4);
    check("a_busy_running", busy, 1);
    wait_done(100, "a_done");
    tick();
    check("a_res0", res_ram[0], 11);
    check("a_res1", res_ram[1], 22);
    check("a_res2", res_ram[2], 33);
    check("a_res3", res_ram[3], 44);
    check("a_cycles_const", cycles, 8);
    check_run_end("a", 4);

    // Zero-length start from DONE.
    begin_run(0);
    do_start(0);
    check("b_done", done, 1);
    check("b_state", state_dbg, ST_DONE);
    check("b_cycles", cycles, 0);
    repeat (5) tick();
    check("b_no_opnd", opnd_cnt, 0);
    check("b_no_write", wr_seen, 0);

    // Reset wins over a simultaneous start.
    begin_run(0);
    reset = 1'b1; start = 1'b1; length = 5;
    tick();
    reset = 1'b0; start = 1'b0;
    check("c_state", state_dbg, ST_IDLE);
    check("c_busy", busy, 0);
    check("c_done", done, 0);
    repeat (4) tick();
    check("c_no_opnd", opnd_cnt, 0);
    check("c_still_idle", state_dbg, ST_IDLE);
    do_start(0);
    check("c_zero_done", done, 1);
    check("c_zero_cycles", cycles, 0);

    // Full-depth run, 1-cycle operator.
    fill_random(DEPTH);
    lat_mode = 1;
    begin_run(DEPTH);
    do_start(DEPTH);
    wait_done(DEPTH + 100, "d_done");
    tick();
    check_run_end("d", DEPTH);
    check("d_consecutive", last_opnd_n - first_opnd_n + 1, DEPTH);
    check("d_last_addr", last_wr_addr, DEPTH - 1);
    check("d_cycles_const", cycles, DEPTH + 2);

    // Unexpected result while in DONE.
    snap = wr_seen;
    inject = 1;
    repeat (3) tick();
    check("g_err_set", err_extra, 1);
    check("g_no_write", wr_seen, snap);

    // Start pulsed mid-run is ignored; new run also clears err_extra.
    fill_random(8);
    lat_mode = 0;
    begin_run(8);
    do_start(8);
    repeat (3) tick();
    length = 3; start = 1'b1;
    tick();
    start = 1'b0;
    check("e_still_busy", busy, 1);
    wait_done(200, "e_done");
    tick();
    check_run_end("e", 8);

    // Variable latency: length 16 then random lengths.
    for (int r = 0; r < 4; r++) begin
      len = (r == 0) ? 16 : int'($urandom_range(1, 64));
      fill_random(len);
      lat_mode = 0;
      begin_run(len);
      do_start(len);
      wait_done(len * 6 + 50, "f_done");
      tick();
      check_run_end("f", len);
      check("f_last_addr", last_wr_addr, len - 1);
    end

    // Reset during DRAIN, later results must be flagged and not written.
    fill_random(8);
    lat_mode = 4;
    begin_run(8);
    do_start(8);
    snap = 0;
    while (state_dbg !== ST_DRAIN && snap < 50) begin
      tick();
      snap++;
    end
    check("h_reached_drain", state_dbg, ST_DRAIN);
    snap = wr_seen;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (8) tick();
    check("h_busy", busy, 0);
    check("h_done", done, 0);
    check("h_state", state_dbg, ST_IDLE);
    check("h_no_write", wr_seen, snap);
    check("h_err", err_extra, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arith_sequencer.md
ARITH_SEQUENCER -- requirements
Module: arith_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: operand/result word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 11: RAM address width.
REQ-003 The block SHALL have port ram_clock, input, 1: single clock; all logic rises on it.
REQ-004 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1: one-cycle request to begin a run.
REQ-006 The block SHALL have port length, input, ADDR_WIDTH+1: word count, sampled on an accepted start.
REQ-007 The block SHALL have port busy, output, 1: run in progress.
REQ-008 The block SHALL have port done, output, 1: last run complete; sticky.
REQ-009 The block SHALL have port cycles, output, 32: cycle count of the last or current run.
REQ-010 The block SHALL have port err_extra, output, 1: sticky flag for an unexpected result.
REQ-011 The block SHALL have port addr_op, output, ADDR_WIDTH: shared read address to the operand X and Y RAM arith ports.
REQ-012 The block SHALL have ports q_x and q_y, input, DATA_WIDTH each: registered RAM read data, valid one cycle after addr_op.
REQ-013 The block SHALL have ports opnd_valid (1), opnd_a and opnd_b (DATA_WIDTH), output: operand issue to the operator.
REQ-014 The block SHALL have ports res_valid (1) and res (DATA_WIDTH), input: operator result, with any latency, in issue order.
REQ-015 The block SHALL have ports addr_res (ADDR_WIDTH), we_res (1) and data_res (DATA_WIDTH), output: result RAM arith port.

Function
REQ-016 The FSM SHALL have the states IDLE, READ, DRAIN and DONE.
REQ-017 In IDLE or DONE, start=1 with length>0 SHALL: latch length; clear rd_cnt, wr_cnt, cycles, done and err_extra; enter READ.
REQ-018 start=1 with length=0 SHALL set done=1 and enter DONE, with zero RAM writes, zero operand issues and cycles=0.
REQ-019 start while busy SHALL be ignored.
REQ-020 In READ, the block SHALL drive addr_op=rd_cnt and increment rd_cnt every cycle, one address per cycle.
REQ-021 When rd_cnt reaches length-1 in READ, the block SHALL issue that address and enter DRAIN next cycle.
REQ-022 opnd_valid SHALL be 1 exactly one cycle after each address issued in READ, with opnd_a=q_x and opnd_b=q_y.
REQ-023 The block SHALL issue exactly length operands per run, at addresses 0..length-1 in order.
REQ-024 Each res_valid received in READ or DRAIN while wr_cnt<length SHALL produce, next cycle: we_res=1, addr_res=wr_cnt, data_res=res; wr_cnt SHALL then increment.
REQ-025 The block SHALL enter DONE when wr_cnt reaches length.
REQ-026 On entering DONE, done SHALL be set and busy SHALL clear on the same edge.
REQ-027 res_valid received in IDLE or DONE, or when wr_cnt=length, SHALL NOT write the RAM and SHALL set err_extra.
REQ-028 busy SHALL be 1 in READ and DRAIN.
REQ-029 cycles SHALL increment every cycle in READ or DRAIN, saturate at 2^32-1, and hold in IDLE and DONE.
REQ-030 The maximum length SHALL be 2^ADDR_WIDTH.
REQ-031 Address counters SHALL carry no wrap-around within a run.
REQ-032 Simultaneous operand issue and result write SHALL both proceed in the same cycle.

Reset
REQ-033 When reset=1, the block SHALL enter IDLE on the next edge.
REQ-034 On reset, busy, done, err_extra, opnd_valid and we_res SHALL be 0, and cycles, addr_op and addr_res SHALL be 0.
REQ-035 Reset SHALL abort a run: the in-flight write SHALL NOT be issued, and later res_valid SHALL set err_extra.
REQ-036 Reset SHALL override a start in the same cycle.

Structure
REQ-037 The state encoding and the default widths SHALL live in a shared package, arith_seq_pkg.
REQ-038 One sub-module, seq_counter (loadable, saturating up-counter), SHALL implement both the rd_cnt/wr_cnt counters and cycles.
REQ-039 All outputs SHALL be registered.
REQ-040 The block SHALL contain no RAM instance of its own.

Verification
REQ-041 Scenario: length=4, RAM X={1,2,3,4}, RAM Y={10,20,30,40}, operator = adder with 3-cycle latency. Required: result RAM 0..3 = {11,22,33,44}, done=1, cycles=8.
REQ-042 Scenario: length=0 start. Required: done=1 next cycle, no opnd_valid, no we_res, cycles=0.
REQ-043 Scenario: length=2048, operator latency 1. Required: opnd_valid high 2048 consecutive cycles, last write at addr_res=2047, no wrap to 0.
REQ-044 Scenario: start pulsed again mid-run at length=8. Required: ignored; exactly 8 writes occur.
REQ-045 Scenario: reset asserted in DRAIN, then a late res_valid. Required: busy=0, no write occurs, err_extra=1.
REQ-046 Scenario: operator with variable latency 1-5 cycles, in order, length=16. Required: all 16 results written to consecutive addresses, err_extra=0.
